// File: rtl/uart_cmd_ctrl.sv
// Serial command sequencer: pops ASCII bytes from the RX FIFO, issues
// stopwatch/clock control pulses or mode toggles, and echoes a response byte.
module uart_cmd_ctrl #(
  parameter bit         ECHO_EN  = 1'b1,
  parameter bit         CASE_INS = 1'b1,
  parameter logic [7:0] ERR_CHAR = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_rdata,
  output logic       rx_rd_en,
  input  logic       tx_full,
  output logic [7:0] tx_wdata,
  output logic       tx_wr_en,
  output logic       o_run_stop,
  output logic       o_clear,
  output logic       o_hour_up,
  output logic       o_min_up,
  output logic       o_sec_up,
  output logic       o_clock_mode,
  output logic       o_msec_min,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    ECHO
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cmd;
  logic [7:0] echo_byte;
  logic [7:0] folded;
  logic       accept;
  logic       tog_mode;
  logic       tog_msec;

  always_comb begin
    folded = rx_rdata;
    if (CASE_INS && (rx_rdata >= 8'h61) && (rx_rdata <= 8'h7A))
      folded = rx_rdata - 8'h20;
  end

  // Decode is evaluated only in EXEC; gating uses the mode level held on entry.
  always_comb begin
    accept     = 1'b0;
    tog_mode   = 1'b0;
    tog_msec   = 1'b0;
    o_run_stop = 1'b0;
    o_clear    = 1'b0;
    o_hour_up  = 1'b0;
    o_min_up   = 1'b0;
    o_sec_up   = 1'b0;
    if (state == EXEC) begin
      case (cmd)
        8'h52: if (!o_clock_mode) begin accept = 1'b1; o_run_stop = 1'b1; end
        8'h43: if (!o_clock_mode) begin accept = 1'b1; o_clear    = 1'b1; end
        8'h48: if (o_clock_mode)  begin accept = 1'b1; o_hour_up  = 1'b1; end
        8'h4D: if (o_clock_mode)  begin accept = 1'b1; o_min_up   = 1'b1; end
        8'h53: if (o_clock_mode)  begin accept = 1'b1; o_sec_up   = 1'b1; end
        8'h57: begin accept = 1'b1; tog_mode = 1'b1; end
        8'h4E: begin accept = 1'b1; tog_msec = 1'b1; end
        default: accept = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    rx_rd_en  = 1'b0;
    tx_wr_en  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_empty) begin
          rx_rd_en  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = EXEC;
      EXEC:  state_nxt = ECHO_EN ? ECHO : IDLE;
      ECHO: begin
        if (!tx_full) begin
          tx_wr_en  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd          <= '0;
      echo_byte    <= '0;
      o_clock_mode <= 1'b0;
      o_msec_min   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH)
        cmd <= folded;
      if (state == EXEC)
        echo_byte <= accept ? cmd : ERR_CHAR;
      if (tog_mode)
        o_clock_mode <= ~o_clock_mode;
      if (tog_msec)
        o_msec_min <= ~o_msec_min;
    end
  end

  assign tx_wdata = echo_byte;
  assign o_busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: FIFO models around the DUT, expected
// responses queued at push time, checked by an independent monitor.
module tb_uart_cmd_ctrl;

  typedef struct {
    logic [7:0] echo;
    int         code;  // 0 none, 1 R, 2 C, 3 H, 4 M, 5 S, 6 W, 7 N
    bit         cm;
    bit         mm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] rx_rdata = 8'h00;
  logic       rx_rd_en;
  logic       tx_full = 1'b0;
  logic [7:0] tx_wdata;
  logic       tx_wr_en;
  logic       o_run_stop, o_clear, o_hour_up, o_min_up, o_sec_up;
  logic       o_clock_mode, o_msec_min, o_busy;

  uart_cmd_ctrl #(
    .ECHO_EN (1'b1),
    .CASE_INS(1'b1),
    .ERR_CHAR(8'h3F)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_empty    (rx_empty),
    .rx_rdata    (rx_rdata),
    .rx_rd_en    (rx_rd_en),
    .tx_full     (tx_full),
    .tx_wdata    (tx_wdata),
    .tx_wr_en    (tx_wr_en),
    .o_run_stop  (o_run_stop),
    .o_clear     (o_clear),
    .o_hour_up   (o_hour_up),
    .o_min_up    (o_min_up),
    .o_sec_up    (o_sec_up),
    .o_clock_mode(o_clock_mode),
    .o_msec_min  (o_msec_min),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         rd_total = 0;
  int         rs_total = 0;
  logic [7:0] rx_q[$];
  exp_t       exp_q[$];
  int         rd_cyc[$];
  bit         m_cm = 1'b0;
  bit         m_mm = 1'b0;
  bit         rd_seen = 1'b0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: what the sequencer should do with one byte, in order.
  function automatic exp_t model(input logic [7:0] b);
    exp_t       e;
    logic [7:0] c;
    c = b;
    if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
    e.code = 0;
    case (c)
      8'h52: if (!m_cm) e.code = 1;
      8'h43: if (!m_cm) e.code = 2;
      8'h48: if (m_cm)  e.code = 3;
      8'h4D: if (m_cm)  e.code = 4;
      8'h53: if (m_cm)  e.code = 5;
      8'h57: begin e.code = 6; m_cm = !m_cm; end
      8'h4E: begin e.code = 7; m_mm = !m_mm; end
      default: e.code = 0;
    endcase
    e.echo = (e.code != 0) ? c : 8'h3F;
    e.cm   = m_cm;
    e.mm   = m_mm;
    return e;
  endfunction

  task automatic push_byte(input logic [7:0] b, input bit with_exp);
    rx_q.push_back(b);
    rx_empty = (rx_q.size() == 0);
    if (with_exp) exp_q.push_back(model(b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [7:0] b);
    step();
    push_byte(b, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0 || o_busy) && n < 2000) begin
      step();
      n++;
    end
    check("drain_done", (n < 2000) ? 1 : 0, 1);
  endtask

  // RX FIFO model: pops on a sampled read strobe, data appears within the next cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rd_seen) begin
      if (rx_q.size() != 0) rx_rdata = rx_q.pop_front();
      rx_empty = (rx_q.size() == 0);
    end
  end

  int  obs = 0;
  bit  prev_cm = 1'b0;
  bit  prev_mm = 1'b0;
  bit  rst_d = 1'b0;
  bit  chk_pop = 1'b0;
  bit  full_seen = 1'b0;

  always @(negedge clk) begin
    int   np;
    int   code;
    exp_t e;
    rd_seen = rx_rd_en;
    if (rst) begin
      obs = 0;
      rd_cyc.delete();
      chk_pop = 1'b0;
      prev_cm = o_clock_mode;
      prev_mm = o_msec_min;
    end else begin
      if (rst_d) begin
        prev_cm = o_clock_mode;
        prev_mm = o_msec_min;
      end
      if (chk_pop) begin
        if (!rx_empty) check("pop_after_echo", rx_rd_en, 1);
        else           check("idle_after_echo", o_busy, 0);
        chk_pop = 1'b0;
      end
      if (rx_rd_en) begin
        rd_total++;
        rd_cyc.push_back(cyc);
        full_seen = tx_full;
        check("rd_not_empty", rx_empty, 0);
        check("rd_in_idle", o_busy, 0);
      end else if (tx_full) begin
        full_seen = 1'b1;
      end
      np = int'(o_run_stop) + int'(o_clear) + int'(o_hour_up) + int'(o_min_up) + int'(o_sec_up);
      if (np != 0) begin
        code = o_run_stop ? 1 : o_clear ? 2 : o_hour_up ? 3 : o_min_up ? 4 : 5;
        if (o_run_stop) rs_total++;
        check("pulse_onehot", np, 1);
        check("pulse_timing", (rd_cyc.size() != 0) ? cyc - rd_cyc[0] : -1, 2);
        obs = code;
      end
      if (o_clock_mode != prev_cm) obs = 6;
      if (o_msec_min != prev_mm)   obs = 7;
      prev_cm = o_clock_mode;
      prev_mm = o_msec_min;
      if (tx_wr_en) begin
        check("wr_not_full", tx_full, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_echo", int'(tx_wdata), -1);
        end else begin
          e = exp_q.pop_front();
          check("echo_byte", int'(tx_wdata), int'(e.echo));
          check("action", obs, e.code);
          check("clock_mode", o_clock_mode, e.cm);
          check("msec_min", o_msec_min, e.mm);
          if (rd_cyc.size() != 0) begin
            if (!full_seen) check("echo_latency", cyc - rd_cyc[0], 3);
            else            check("echo_latency_min", (cyc - rd_cyc[0] >= 3) ? 1 : 0, 1);
            void'(rd_cyc.pop_front());
          end else begin
            check("echo_without_pop", 0, 1);
          end
        end
        obs = 0;
        chk_pop = 1'b1;
      end
    end
    rst_d = rst;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tbl[14];
    int         r0, s0, k;
    tbl = '{8'h52, 8'h43, 8'h48, 8'h4D, 8'h53, 8'h57, 8'h4E,
            8'h72, 8'h63, 8'h68, 8'h6D, 8'h77, 8'h6E, 8'h5A};

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", o_busy, 0);
    check("reset_rd_en", rx_rd_en, 0);
    check("reset_wr_en", tx_wr_en, 0);
    check("reset_mode", {o_clock_mode, o_msec_min}, 0);
    check("reset_pulses", {o_run_stop, o_clear, o_hour_up, o_min_up, o_sec_up}, 0);
    check("reset_wdata", tx_wdata, 0);

    push_seq(8'h52);
    drain();
    push_seq(8'h72);
    push_seq(8'h5A);
    drain();
    push_seq(8'h57);
    push_seq(8'h48);
    push_seq(8'h43);
    drain();
    push_seq(8'h57);
    drain();

    // tx_full stall: one pop only, then release
    step();
    tx_full = 1'b1;
    r0 = rd_total;
    push_byte(8'h52, 1'b1);
    push_seq(8'h52);
    repeat (12) step();
    check("stall_single_pop", rd_total - r0, 1);
    check("stall_busy", o_busy, 1);
    tx_full = 1'b0;
    drain();
    check("stall_total_pops", rd_total - r0, 2);

    r0 = rd_total;
    s0 = rs_total;
    step();
    for (int i = 0; i < 4; i++) push_byte(8'h52, 1'b1);
    drain();
    check("b2b_pops", rd_total - r0, 4);
    check("b2b_pulses", rs_total - s0, 4);

    // reset in EXEC of 'N'
    step();
    push_byte(8'h4E, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rx_rd_en && k < 20);
    check("rst_test_pop_seen", rx_rd_en, 1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_cm = 1'b0;
    m_mm = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_msec_min", o_msec_min, 0);
    check("rst_clock_mode", o_clock_mode, 0);
    check("rst_busy", o_busy, 0);
    push_seq(8'h4E);
    drain();

    for (int i = 0; i < 400; i++) begin
      step();
      tx_full = ($urandom_range(0, 3) == 0);
      if (rx_q.size() < 6 && $urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 3) != 0) push_byte(tbl[$urandom_range(0, 13)], 1'b1);
        else                           push_byte(8'($urandom), 1'b1);
      end
    end
    step();
    tx_full = 1'b0;
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
